// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and segment table for the 7-segment display blocks
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}, indexed by nibble value 0..F.
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_scan_ctrl_hex_decode.sv
// rtl/seg_scan_ctrl_hex_decode.sv - nibble plus decimal point to active-low segment byte
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, HEX7_TABLE[nibble]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan with blanking; LZ_SUPPRESS_EN enables leading-zero suppression
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter  int DIGITS       = 8,
    parameter  int BLANK_CYCLES = 50,
    localparam int IDXW         = $clog2(DIGITS)
) (
    input  logic                  clk50MHz_i,
    input  logic                  rst_i,
    input  logic                  scan_i,
    input  logic                  en_i,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [7:0]            seg_o,
    output logic [IDXW-1:0]       digit_o,
    output logic                  frame_o
);

    localparam int              CNTW     = $clog2(BLANK_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BLANK_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

    logic s1, s2, s3;
    logic tick;

    state_t            state_q, state_n;
    logic [CNTW-1:0]   cnt_q, cnt_n;
    logic [DIGITS-1:0] an_n;
    logic [7:0]        seg_n;
    logic [IDXW-1:0]   digit_n;
    logic              frame_n;

    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic [7:0]        cur_seg;
    logic              suppress;

    assign tick = s2 & ~s3;

    assign cur_nib = data_i[{digit_o, 2'b00} +: 4];
    assign cur_dp  = dp_i[digit_o];

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .seg    (cur_seg)
    );

    // Suppression is decided from the live inputs on the edge that enters SHOW,
    // so it always matches the snapshot that gets displayed.
`ifdef LZ_SUPPRESS_EN
    assign suppress = (digit_o != '0)
                    && ((data_i >> {digit_o, 2'b00}) == '0)
                    && !cur_dp;
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk50MHz_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= scan_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk50MHz_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            an_o    <= '1;
            seg_o   <= SEG_OFF;
            digit_o <= '0;
            frame_o <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            an_o    <= an_n;
            seg_o   <= seg_n;
            digit_o <= digit_n;
            frame_o <= frame_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        an_n    = an_o;
        seg_n   = seg_o;
        digit_n = digit_o;
        frame_n = 1'b0;

        if (!en_i) begin
            state_n = IDLE;
            cnt_n   = '0;
            digit_n = '0;
            an_n    = '1;
            seg_n   = SEG_OFF;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    digit_n = '0;
                    an_n    = '1;
                    seg_n   = SEG_OFF;
                end
                BLANK: begin
                    an_n  = '1;
                    seg_n = SEG_OFF;
                    if (cnt_q == CNT_LAST) begin
                        state_n = SHOW;
                        cnt_n   = '0;
                        if (!suppress) begin
                            an_n  = ~(DIGITS'(1) << digit_o);
                            seg_n = cur_seg;
                        end
                    end else begin
                        cnt_n = cnt_q + CNTW'(1);
                    end
                end
                SHOW: begin
                    // Segment/anode registers hold the entry snapshot until the tick.
                    if (tick) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        an_n    = '1;
                        seg_n   = SEG_OFF;
                        if (digit_o == IDX_LAST) begin
                            digit_n = '0;
                            frame_n = 1'b1;
                        end else begin
                            digit_n = digit_o + IDXW'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    digit_n = '0;
                    an_n    = '1;
                    seg_n   = SEG_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    logic        clk50MHz_i = 1'b0;
    logic        rst_i;
    logic        scan_i;
    logic        en_i;
    logic [31:0] data_i;
    logic [7:0]  dp_i;
    logic [7:0]  an_o;
    logic [7:0]  seg_o;
    logic [2:0]  digit_o;
    logic        frame_o;

    int n_pass  = 0;
    int n_total = 0;

    always #10 clk50MHz_i = ~clk50MHz_i;

    seg_scan_ctrl dut (
        .clk50MHz_i (clk50MHz_i),
        .rst_i      (rst_i),
        .scan_i     (scan_i),
        .en_i       (en_i),
        .data_i     (data_i),
        .dp_i       (dp_i),
        .an_o       (an_o),
        .seg_o      (seg_o),
        .digit_o    (digit_o),
        .frame_o    (frame_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk50MHz_i);
        #1;
    endtask

    function automatic logic [7:0] seg_code(input logic [3:0] nib, input logic dp);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
            4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
            4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
            4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
        endcase
        if (dp) s[7] = 1'b0;
        return s;
    endfunction

    function automatic logic [7:0] an_code(input int d);
        return ~(8'h01 << d);
    endfunction

    initial begin
        logic [3:0] nib;
        rst_i  = 1'b1;
        en_i   = 1'b0;
        scan_i = 1'b0;
        data_i = 32'h12345678;
        dp_i   = 8'h00;

        #1;
        check("rst_an", an_o, 8'hFF);
        check("rst_seg", seg_o, 8'hFF);
        check("rst_digit", digit_o, 0);
        check("rst_frame", frame_o, 0);
        step(2);
        rst_i = 1'b0;
        step(1);
        check("idle_an", an_o, 8'hFF);

        en_i = 1'b1;
        step(1);
        check("blank_first_an", an_o, 8'hFF);
        step(49);
        check("blank_last_an", an_o, 8'hFF);
        check("blank_last_seg", seg_o, 8'hFF);
        step(1);
        check("show0_an", an_o, 8'hFE);
        check("show0_seg", seg_o, 8'h80);
        check("show0_digit", digit_o, 0);

        for (int i = 1; i <= 8; i++) begin
            scan_i = 1'b1;
            step(2);
            check("pre_tick_an", an_o, an_code((i - 1) % 8));
            step(1);
            check("tick_an", an_o, 8'hFF);
            check("tick_digit", digit_o, i % 8);
            check("tick_frame", frame_o, (i == 8) ? 1 : 0);
            scan_i = 1'b0;
            step(1);
            check("frame_one_cycle", frame_o, 0);
            step(49);
            nib = data_i[4*(i%8) +: 4];
            check("scan_an", an_o, an_code(i % 8));
            check("scan_seg", seg_o, seg_code(nib, 1'b0));
            check("scan_digit", digit_o, i % 8);
        end

        data_i = 32'h12345670;
        dp_i   = 8'h01;
        step(2);
        check("latched_seg", seg_o, 8'h80);
        en_i = 1'b0;
        step(1);
        check("disable_an", an_o, 8'hFF);
        check("disable_digit", digit_o, 0);
        en_i = 1'b1;
        step(51);
        check("dp_seg", seg_o, 8'h40);
        check("dp_an", an_o, 8'hFE);

        scan_i = 1'b1;
        step(3);
        scan_i = 1'b0;
        check("drop_enter_digit", digit_o, 1);
        step(10);
        scan_i = 1'b1;
        step(3);
        scan_i = 1'b0;
        check("drop_blank_an", an_o, 8'hFF);
        check("drop_blank_digit", digit_o, 1);
        step(37);
        check("drop_show_an", an_o, 8'hFD);
        check("drop_show_seg", seg_o, 8'hF8);
        step(5);
        check("drop_no_step", digit_o, 1);

        scan_i = 1'b1;
        step(2);
        en_i = 1'b0;
        step(1);
        check("en_tick_an", an_o, 8'hFF);
        check("en_tick_digit", digit_o, 0);
        check("en_tick_frame", frame_o, 0);
        scan_i = 1'b0;
        step(2);

        en_i = 1'b1;
        step(51);
        check("pre_rst_an", an_o, 8'hFE);
        rst_i = 1'b1;
        #1;
        check("async_rst_an", an_o, 8'hFF);
        check("async_rst_seg", seg_o, 8'hFF);
        check("async_rst_digit", digit_o, 0);
        check("async_rst_frame", frame_o, 0);
        step(2);
        check("rst_hold_frame", frame_o, 0);
        en_i  = 1'b0;
        rst_i = 1'b0;
        step(1);

        data_i = 32'h00000305;
        dp_i   = 8'h00;
        en_i   = 1'b1;
        step(51);
        check("lz_d0_seg", seg_o, 8'h92);
        for (int d = 1; d < 8; d++) begin
            scan_i = 1'b1;
            step(3);
            scan_i = 1'b0;
            step(50);
            nib = data_i[4*d +: 4];
            check("lz_digit", digit_o, d);
`ifdef LZ_SUPPRESS_EN
            if (d >= 3) begin
                check("lz_an", an_o, 8'hFF);
                check("lz_seg", seg_o, 8'hFF);
            end else begin
                check("lz_an", an_o, an_code(d));
                check("lz_seg", seg_o, seg_code(nib, 1'b0));
            end
`else
            check("lz_an", an_o, an_code(d));
            check("lz_seg", seg_o, seg_code(nib, 1'b0));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
